// File: rtl/adder_pkg.sv
// Shared geometry for the pipelined carry-lookahead subtractor.
package adder_pkg;
  localparam int WIDTH      = 64;
  localparam int SLICE      = 16;
  localparam int NUM_STAGES = WIDTH / SLICE;
endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead adder: 4-bit groups with a second
// lookahead level across the four group carries.
module cla16_slice
  import adder_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  always_comb begin
    w_g = a & b;
    w_p = a ^ b;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | ((&w_p[4*j+2 +: 2]) & w_g[4*j+1])
              | ((&w_p[4*j+1 +: 3]) & w_g[4*j]);
      w_gp[j] = &w_p[4*j +: 4];
    end
    w_gc[0] = cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | ((&w_gp[1:0]) & cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | ((&w_gp[2:1]) & w_gg[0])
            | ((&w_gp[2:0]) & cin);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | ((&w_gp[3:2]) & w_gg[1])
            | ((&w_gp[3:1]) & w_gg[0]) | ((&w_gp) & cin);
    // Bit carries inside each group are derived from that group's carry-in.
    for (int j = 0; j < 4; j++) begin
      w_c[4*j]   = w_gc[j];
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
    end
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_gc[4];

endmodule

// File: rtl/cla_pipelined_subtractor.sv
// 64-bit unsigned subtractor, one 16-bit lookahead slice resolved per stage,
// valid/ready handshake with per-stage bubble collapse.
module cla_pipelined_subtractor #(
  parameter int WIDTH = adder_pkg::WIDTH,
  parameter int SLICE = adder_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sayi1,
  input  logic [WIDTH-1:0] sayi2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fark,
  output logic             borrow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE;

  // Token: operands (b already inverted), partially assembled result, carry.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             c;
  } stage_t;

  stage_t [STAGES-1:0]            w_src;
  stage_t [STAGES-1:0]            w_nxt;
  logic   [STAGES-1:0][SLICE-1:0] w_sum;
  logic   [STAGES-1:0]            w_cout;
  logic   [STAGES-1:0]            w_load;
  logic                           w_unused_ab;

  stage_t [STAGES-2:0]            r_stg;
  logic   [STAGES-2:0]            r_vld;
  logic                           r_out_vld;
  logic   [WIDTH-1:0]             r_fark;
  logic                           r_borrow;
  logic                           r_zero;

  always_comb begin
    w_src[0].a = sayi1;
    w_src[0].b = ~sayi2;
    w_src[0].r = '0;
    w_src[0].c = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      w_src[k] = r_stg[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla16_slice u_slice (
      .a    (w_src[k].a[k*SLICE +: SLICE]),
      .b    (w_src[k].b[k*SLICE +: SLICE]),
      .cin  (w_src[k].c),
      .sum  (w_sum[k]),
      .cout (w_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k]                     = w_src[k];
      w_nxt[k].r[k*SLICE +: SLICE] = w_sum[k];
      w_nxt[k].c                   = w_cout[k];
    end
  end

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    w_load[STAGES-1] = !r_out_vld || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_load[k] = !r_vld[k] || w_load[k+1];
    end
  end

  assign w_unused_ab = ^{w_nxt[STAGES-1].a, w_nxt[STAGES-1].b};

  // ---- stage boundary: valids and output stage (reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_out_vld <= 1'b0;
      r_fark    <= '0;
      r_borrow  <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      if (w_load[0]) r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES - 1; k++) begin
        if (w_load[k]) r_vld[k] <= r_vld[k-1];
      end
      if (w_load[STAGES-1]) begin
        r_out_vld <= r_vld[STAGES-2];
        if (r_vld[STAGES-2]) begin
          r_fark   <= w_nxt[STAGES-1].r;
          r_borrow <= ~w_nxt[STAGES-1].c;
          r_zero   <= (w_nxt[STAGES-1].r == '0);
        end
      end
    end
  end

  // ---- stage boundary: intermediate token data (no reset) ----
  always_ff @(posedge clk) begin
    if (w_load[0] && in_valid) r_stg[0] <= w_nxt[0];
    for (int k = 1; k < STAGES - 1; k++) begin
      if (w_load[k] && r_vld[k-1]) r_stg[k] <= w_nxt[k];
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_out_vld;
  assign fark      = r_fark;
  assign borrow    = r_borrow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Directed-vector bench for cla_pipelined_subtractor.
module tb_cla_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sayi1;
  logic [63:0] sayi2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fark;
  logic        borrow;
  logic        zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_pipelined_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sayi1     (sayi1),
    .sayi2     (sayi2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fark      (fark),
    .borrow    (borrow),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ef, input logic eb, input logic ez);
    int lat;
    out_ready = 1'b1;
    sayi1     = a;
    sayi2     = b;
    in_valid  = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_fark"}, fark, ef);
    check({tag, "_borrow"}, 64'(borrow), 64'(eb));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    tick();
  endtask

  task automatic stall_test();
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [63:0] ef [6];
    logic        eb [6];
    int sent = 0;
    int got  = 0;
    int idx;
    va = '{64'd10, 64'd20, 64'd1, 64'h0000_0001_0000_0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    vb = '{64'd1, 64'd5, 64'd2, 64'd1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    ef = '{64'd9, 64'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd1};
    eb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 2 && c <= 9);
      idx       = (sent < 6) ? sent : 5;
      in_valid  = (sent < 6);
      sayi1     = va[idx];
      sayi2     = vb[idx];
      #1;
      if (c == 4) check("stall_accepted_before_full", 64'(sent), 64'd4);
      if (c >= 4 && c <= 9) check("stall_in_ready_low", 64'(in_ready), 64'd0);
      if (c == 10) check("stall_in_ready_release", 64'(in_ready), 64'd1);
      if (out_valid) begin
        if (got < 6) begin
          check("stall_fark", fark, ef[got]);
          check("stall_borrow", 64'(borrow), 64'(eb[got]));
          if (out_ready) got++;
        end else begin
          check("stall_extra_result", 64'(out_valid), 64'd0);
        end
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("stall_results_delivered", 64'(got), 64'd6);
  endtask

  task automatic reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sayi1     = 64'd9;
    sayi2     = 64'd4;
    #1;
    tick();
    sayi1 = 64'd8;
    sayi2 = 64'd2;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("midrst_stale_results", 64'(stale), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sayi1     = '0;
    sayi2     = '0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fark", fark, 64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_one("sub_5_3", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0);
    run_one("sub_0_1", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("slice_ripple", 64'h0000_0000_0001_0000, 64'd1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
    run_one("equal_ops", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b1);
    stall_test();
    reset_midflight();
    run_one("after_rst_7_7", 64'd7, 64'd7, 64'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipelined_subtractor.md
CLA_PIPELINED_SUBTRACTOR -- requirements
Module: cla_pipelined_subtractor

Interface
REQ-001 SHALL use parameter WIDTH, default 64, meaning operand/result width in bits; it SHALL be fixed at 64 in this release.
REQ-002 SHALL use parameter SLICE, default 16, meaning bits resolved per pipeline stage; WIDTH/SLICE = 4 stages.
REQ-003 SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning sayi1/sayi2 carry a request.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port sayi1, input, 64, the minuend (unsigned).
REQ-008 SHALL have port sayi2, input, 64, the subtrahend (unsigned).
REQ-009 SHALL have port out_valid, output, 1, meaning fark/borrow/zero are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream consumes the result.
REQ-011 SHALL have port fark, output, 64, holding sayi1 - sayi2 mod 2^64.
REQ-012 SHALL have port borrow, output, 1, set to 1 when sayi1 < sayi2 unsigned.
REQ-013 SHALL have port zero, output, 1, set to 1 when fark == 0.

Function
REQ-014 SHALL compute fark = sayi1 + ~sayi2 + 1; slice k (bits 16k+15:16k) SHALL be resolved in stage k by a carry-lookahead slice, with stage 0 carry-in = 1.
REQ-015 SHALL register each stage's carry-out and feed it to the next stage's carry-in; borrow SHALL equal ~(final carry-out).
REQ-016 SHALL carry unresolved upper operand slices forward with the token and delay resolved lower result slices alongside, so that fark is assembled coherently at stage 3.
REQ-017 SHALL accept a transfer when in_valid && in_ready, and deliver a transfer when out_valid && out_ready.
REQ-018 SHALL have a latency of exactly 4 cycles from acceptance to out_valid when there is no backpressure, with throughput of one result per cycle.
REQ-019 SHALL give each stage a valid bit; a stage SHALL advance when the next stage is empty or advancing (per-stage bubble collapse), and SHALL otherwise hold.
REQ-020 SHALL drive in_ready = !stage0_valid || stage0_advances; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL hold fark/borrow/zero stable while out_valid && !out_ready.
REQ-022 SHALL, when full (4 tokens) with out_ready=0, deassert in_ready and drop no token; when out_ready rises, a new input SHALL be accepted in the same cycle.
REQ-023 SHALL emit results in acceptance order; equal operands SHALL give fark=0, zero=1, borrow=0.
REQ-024 SHALL compute zero over the final assembled fark in the output stage, with no extra cycle.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid, fark, borrow and zero to 0; in_ready SHALL read 1 during and after reset.
REQ-026 SHALL discard in-flight tokens when reset asserts mid-operation; no result SHALL appear after release until new input is accepted.
REQ-027 SHALL reset only the datapath registers it needs to (valids mandatory; data clears to 0 per REQ-025).

Structure
REQ-028 SHALL place WIDTH, SLICE and NUM_STAGES (=WIDTH/SLICE) in a shared package, adder_pkg.
REQ-029 SHALL instantiate one sub-module, cla16_slice: combinational 16-bit generate/propagate lookahead with inputs a, b, cin and outputs sum, cout; it SHALL be instantiated once per stage.

Verification
REQ-030 SHALL be verified with the following directed scenarios:
- 5 - 3 accepted at cycle 0 -> out_valid at cycle 4, fark=2, borrow=0, zero=0.
- 0 - 1 -> fark=FFFF_FFFF_FFFF_FFFF, borrow=1, zero=0.
- 0x0000_0000_0001_0000 - 1 (borrow ripples through a slice boundary) -> fark=0x0000_0000_0000_FFFF, borrow=0.
- Equal operands 0xDEAD_BEEF_0123_4567 -> fark=0, zero=1, borrow=0.
- 6 back-to-back inputs, out_ready=0 for cycles 2-9 -> in_ready drops after the 4th acceptance, all 6 results emerge in order with no loss and stable outputs while stalled.
- rst_n pulsed low at cycle 2 with 2 tokens in flight -> out_valid stays 0 and no stale result appears; a subsequent 7 - 7 yields zero=1.
